draw_triangle_clip: RTL and testbench

//  Draws a filled or outlined triangle as a stream of pixel coordinates, clipped to a

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/clip_span.sv | 31 +++
 rtl/draw_line.sv | 60 ++++++
 rtl/draw_line_1d.sv | 28 ++
 rtl/draw_triangle_clip.sv | 189 ++++++++++++++++++
 tb/tb_draw_triangle_clip.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics types for the primitive drawers (triangle, rectangle, circle).
//   CORDW        default signed coordinate width
//   draw_mode_t  fill or outline
//   clip_win_t   inclusive clipping window {x0,y0,x1,y1}
//   tri_state_t  triangle drawer sequencing states
package gfx_pkg;
  localparam int CORDW = 16;

  typedef enum logic {DRAW_FILL = 1'b0, DRAW_OUTLINE = 1'b1} draw_mode_t;

  typedef struct packed {
    logic signed [CORDW-1:0] x0;
    logic signed [CORDW-1:0] y0;
    logic signed [CORDW-1:0] x1;
    logic signed [CORDW-1:0] y1;
  } clip_win_t;

  typedef enum logic [3:0] {
    IDLE, SORT_0, SORT_1, SORT_2, INIT_A, INIT_B0, INIT_B1, START_A,
    START_B, EDGE, CLIP_H, START_H, H_LINE, OUT_INIT, OUT_LINE, DONE
  } tri_state_t;
endpackage

// File: rtl/clip_span.sv
// Registered span clamp. On en, clamps [lo,hi] on row y to the window and
// flags rows/spans with no visible pixel (including an inverted window).
//   clk, rst, en, y, lo, hi, win_x0..win_y1  ->  clo, chi, reject
module clip_span #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [CORDW-1:0] y,
  input  logic signed [CORDW-1:0] lo,
  input  logic signed [CORDW-1:0] hi,
  input  logic signed [CORDW-1:0] win_x0,
  input  logic signed [CORDW-1:0] win_y0,
  input  logic signed [CORDW-1:0] win_x1,
  input  logic signed [CORDW-1:0] win_y1,
  output logic signed [CORDW-1:0] clo,
  output logic signed [CORDW-1:0] chi,
  output logic                    reject
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clo <= '0; chi <= '0; reject <= 1'b0;
    end else if (en) begin
      reject <= (win_x0 > win_x1) || (win_y0 > win_y1) ||
                (y < win_y0) || (y > win_y1) || (hi < win_x0) || (lo > win_x1);
      clo    <= (lo < win_x0) ? win_x0 : lo;
      chi    <= (hi > win_x1) ? win_x1 : hi;
    end
  end
endmodule

// File: rtl/draw_line.sv
// Bresenham line engine. start loads endpoints; the current point (x,y) is
// valid while busy=1 and is consumed (stepped past) on a cycle with oe=1.
// busy drops once the end point has been consumed.
//   clk, rst          clock, async active-high reset
//   start, oe         load / consume current point
//   x0,y0,x1,y1       signed endpoints
//   x, y, busy        current point and valid flag
module draw_line #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    busy
);
  // Deltas span 2^CORDW, doubled error needs two more bits plus sign.
  localparam int EW = CORDW + 3;

  logic signed [EW-1:0] dx, dy, err, e2, ldx, ldy, adx, ady;
  logic signed [CORDW-1:0] xe, ye;
  logic sx_neg, sy_neg, movx, movy;

  always_comb begin
    ldx  = EW'(x1) - EW'(x0);
    ldy  = EW'(y1) - EW'(y0);
    adx  = (ldx < 0) ? -ldx : ldx;
    ady  = (ldy < 0) ? -ldy : ldy;
    e2   = err <<< 1;
    movx = (e2 >= dy);
    movy = (e2 <= dx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0; y <= '0; xe <= '0; ye <= '0;
      dx <= '0; dy <= '0; err <= '0;
      sx_neg <= 1'b0; sy_neg <= 1'b0; busy <= 1'b0;
    end else if (start) begin
      x <= x0; y <= y0; xe <= x1; ye <= y1;
      dx <= adx; dy <= -ady; err <= adx - ady;
      sx_neg <= (x1 < x0); sy_neg <= (y1 < y0);
      busy <= 1'b1;
    end else if (busy && oe) begin
      if (x == xe && y == ye) begin
        busy <= 1'b0;
      end else begin
        err <= err + (movx ? dy : '0) + (movy ? dx : '0);
        if (movx) x <= sx_neg ? x - 1'b1 : x + 1'b1;
        if (movy) y <= sy_neg ? y - 1'b1 : y + 1'b1;
      end
    end
  end
endmodule

// File: rtl/draw_line_1d.sv
// Horizontal span walker from x0 up to x1 (x0 <= x1). Current x valid while
// busy; consumed on oe=1.
//   clk, rst, start, oe, x0, x1  ->  x, busy
module draw_line_1d #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] x1,
  output logic signed [CORDW-1:0] x,
  output logic                    busy
);
  logic signed [CORDW-1:0] xe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0; xe <= '0; busy <= 1'b0;
    end else if (start) begin
      x <= x0; xe <= x1; busy <= 1'b1;
    end else if (busy && oe) begin
      if (x == xe) busy <= 1'b0;
      else         x <= x + 1'b1;
    end
  end
endmodule

// File: rtl/draw_triangle_clip.sv
// Filled / outlined triangle drawer with window clipping.
// Vertices are y-sorted; fill walks edge A (v0->v2) and edge B (v0->v1->v2)
// one scanline at a time, collecting the row's x extent, then clamps and
// emits the span. Outline walks the three edges on one line engine and
// masks out-of-window pixels. oe=0 freezes all sequencing.
//   clk, rst                 clock, async active-high reset
//   start, oe, mode          request, output enable, 0 fill / 1 outline
//   x0..y2, clip_x0..clip_y1 vertices and inclusive window (latched on start)
//   x, y, drawing            registered pixel and valid
//   busy, done               request in progress / completion pulse
module draw_triangle_clip import gfx_pkg::*; #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic                    mode,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic signed [CORDW-1:0] x2,
  input  logic signed [CORDW-1:0] y2,
  input  logic signed [CORDW-1:0] clip_x0,
  input  logic signed [CORDW-1:0] clip_y0,
  input  logic signed [CORDW-1:0] clip_x1,
  input  logic signed [CORDW-1:0] clip_y1,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);
  localparam logic signed [CORDW-1:0] CMAX = {1'b0, {(CORDW-1){1'b1}}};
  localparam logic signed [CORDW-1:0] CMIN = {1'b1, {(CORDW-1){1'b0}}};

  tri_state_t state, state_n;
  draw_mode_t mode_r;
  logic signed [CORDW-1:0] vx [3];
  logic signed [CORDW-1:0] vy [3];
  logic signed [CORDW-1:0] wx0, wy0, wx1, wy1, row, span_lo, span_hi;
  logic bseg;
  logic [1:0] oseg;

  logic a_start, a_oe, a_busy, b_start, b_oe, b_busy, h_start, h_oe, h_busy;
  logic c_en, c_rej, accept, last_row, pix_vld;
  logic signed [CORDW-1:0] a_x0, a_y0, a_x1, a_y1, b_x0, b_y0, b_x1, b_y1;
  logic signed [CORDW-1:0] ax, ay, bx, by, hx, c_lo, c_hi, pix_x, pix_y;

  // A start in the done cycle is refused so the earliest restart is one later.
  assign accept   = start && (state == IDLE) && !done;
  assign last_row = (row == vy[2]);

  draw_line #(.CORDW(CORDW)) u_line_a (
    .clk, .rst, .start(a_start), .oe(a_oe),
    .x0(a_x0), .y0(a_y0), .x1(a_x1), .y1(a_y1), .x(ax), .y(ay), .busy(a_busy));

  draw_line #(.CORDW(CORDW)) u_line_b (
    .clk, .rst, .start(b_start), .oe(b_oe),
    .x0(b_x0), .y0(b_y0), .x1(b_x1), .y1(b_y1), .x(bx), .y(by), .busy(b_busy));

  draw_line_1d #(.CORDW(CORDW)) u_span (
    .clk, .rst, .start(h_start), .oe(h_oe), .x0(c_lo), .x1(c_hi),
    .x(hx), .busy(h_busy));

  clip_span #(.CORDW(CORDW)) u_clip (
    .clk, .rst, .en(c_en), .y(row), .lo(span_lo), .hi(span_hi),
    .win_x0(wx0), .win_y0(wy0), .win_x1(wx1), .win_y1(wy1),
    .clo(c_lo), .chi(c_hi), .reject(c_rej));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = SORT_0;
      SORT_0:   state_n = SORT_1;
      SORT_1:   state_n = SORT_2;
      SORT_2:   state_n = (mode_r == DRAW_OUTLINE) ? OUT_INIT : INIT_A;
      INIT_A:   state_n = INIT_B0;
      INIT_B0:  state_n = START_A;
      START_A:  if (!(a_busy && ay == row)) state_n = START_B;
      START_B:  begin
        if (b_busy && by == row) state_n = START_B;
        else if (!b_busy && !bseg) state_n = INIT_B1;  // chain v1->v2
        else state_n = EDGE;
      end
      INIT_B1:  state_n = START_B;
      EDGE:     state_n = CLIP_H;
      CLIP_H:   state_n = !c_rej ? START_H : (last_row ? DONE : START_A);
      START_H:  state_n = H_LINE;
      H_LINE:   if (!h_busy) state_n = last_row ? DONE : START_A;
      OUT_INIT: state_n = OUT_LINE;
      OUT_LINE: if (!a_busy) state_n = (oseg == 2'd2) ? DONE : OUT_INIT;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (!oe && state != IDLE && state != DONE) state_n = state;
  end

  always_comb begin
    a_start = oe && (state == INIT_A || state == OUT_INIT);
    a_oe    = oe && ((state == START_A && ay == row) || state == OUT_LINE);
    b_start = oe && (state == INIT_B0 || state == INIT_B1);
    b_oe    = oe && state == START_B && by == row;
    c_en    = oe && state == EDGE;
    h_start = oe && state == START_H;
    h_oe    = oe && state == H_LINE;
    a_x0 = vx[0]; a_y0 = vy[0]; a_x1 = vx[2]; a_y1 = vy[2];
    if (state == OUT_INIT) begin
      case (oseg)
        2'd0:    begin a_x1 = vx[1]; a_y1 = vy[1]; end
        2'd1:    begin a_x0 = vx[1]; a_y0 = vy[1]; end
        default: begin a_x0 = vx[2]; a_y0 = vy[2]; a_x1 = vx[0]; a_y1 = vy[0]; end
      endcase
    end
    b_x0 = vx[0]; b_y0 = vy[0]; b_x1 = vx[1]; b_y1 = vy[1];
    if (state == INIT_B1) begin
      b_x0 = vx[1]; b_y0 = vy[1]; b_x1 = vx[2]; b_y1 = vy[2];
    end
    pix_vld = 1'b0; pix_x = hx; pix_y = row;
    if (state == H_LINE && h_busy && oe) begin
      pix_vld = 1'b1;
    end else if (state == OUT_LINE && a_busy && oe) begin
      pix_x   = ax;
      pix_y   = ay;
      pix_vld = (ax >= wx0) && (ax <= wx1) && (ay >= wy0) && (ay <= wy1);
    end
  end

  // Latched request, sort network and per-row span accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin vx[i] <= '0; vy[i] <= '0; end
      wx0 <= '0; wy0 <= '0; wx1 <= '0; wy1 <= '0;
      mode_r <= DRAW_FILL; row <= '0; span_lo <= CMAX; span_hi <= CMIN;
      bseg <= 1'b0; oseg <= '0;
    end else if (accept) begin
      vx[0] <= x0; vy[0] <= y0; vx[1] <= x1; vy[1] <= y1; vx[2] <= x2; vy[2] <= y2;
      wx0 <= clip_x0; wy0 <= clip_y0; wx1 <= clip_x1; wy1 <= clip_y1;
      mode_r <= draw_mode_t'(mode); bseg <= 1'b0; oseg <= '0;
    end else if (oe) begin
      case (state)
        // Strict compare keeps equal-y vertices in input order.
        SORT_0, SORT_2: if (vy[1] < vy[0]) begin
          vx[0] <= vx[1]; vy[0] <= vy[1]; vx[1] <= vx[0]; vy[1] <= vy[0];
        end
        SORT_1: if (vy[2] < vy[1]) begin
          vx[1] <= vx[2]; vy[1] <= vy[2]; vx[2] <= vx[1]; vy[2] <= vy[1];
        end
        INIT_A: begin row <= vy[0]; span_lo <= CMAX; span_hi <= CMIN; end
        START_A: if (a_busy && ay == row) begin
          if (ax < span_lo) span_lo <= ax;
          if (ax > span_hi) span_hi <= ax;
        end
        START_B: if (b_busy && by == row) begin
          if (bx < span_lo) span_lo <= bx;
          if (bx > span_hi) span_hi <= bx;
        end
        INIT_B1: bseg <= 1'b1;
        CLIP_H: if (c_rej && !last_row) begin
          row <= row + 1'b1; span_lo <= CMAX; span_hi <= CMIN;
        end
        H_LINE: if (!h_busy && !last_row) begin
          row <= row + 1'b1; span_lo <= CMAX; span_hi <= CMIN;
        end
        OUT_LINE: if (!a_busy) oseg <= oseg + 2'd1;
        default: ;
      endcase
    end
  end

  // Output register: one cycle behind the engines; busy/done track it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0; y <= '0; drawing <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      drawing <= pix_vld;
      if (pix_vld) begin x <= pix_x; y <= pix_y; end
      done <= (state == DONE);
      if (accept)              busy <= 1'b1;
      else if (state == DONE)  busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_draw_triangle_clip.sv
// Directed bench for draw_triangle_clip: fill, clipped fill, outline,
// off-window and inverted windows, oe stalls, degenerate shapes, reset abort.
module tb_draw_triangle_clip;
  logic clk = 1'b0;
  logic rst, start, oe, mode, drawing, busy, done;
  logic signed [15:0] x0, y0, x1, y1, x2, y2, cx0, cy0, cx1, cy1, x, y;

  int checks = 0, passes = 0;
  int qx[$], qy[$];
  int done_cnt = 0, busy_at_done = 0, busy_after_start = 0;

  always #5 clk = ~clk;

  draw_triangle_clip #(.CORDW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .oe(oe), .mode(mode),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .clip_x0(cx0), .clip_y0(cy0), .clip_x1(cx1), .clip_y1(cy1),
    .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done));

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) if (!rst) begin
    if (drawing) begin qx.push_back(int'(x)); qy.push_back(int'(y)); end
    if (done) begin done_cnt++; busy_at_done = int'(busy); end
  end

  function automatic int seq_err(int ex[$], int ey[$], int gx[$], int gy[$]);
    int e = 0;
    if (gx.size() != ex.size()) e++;
    for (int i = 0; i < ex.size() && i < gx.size(); i++)
      if (gx[i] != ex[i] || gy[i] != ey[i]) e++;
    return e;
  endfunction

  task automatic run(string tag, logic m, int ax0, int ay0, int ax1, int ay1,
                     int ax2, int ay2, int wx0, int wy0, int wx1, int wy1,
                     bit toggle, int poke);
    int cyc;
    qx.delete(); qy.delete(); done_cnt = 0; busy_at_done = -1;
    @(posedge clk); #1;
    mode = m; x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1);
    x2 = 16'(ax2); y2 = 16'(ay2);
    cx0 = 16'(wx0); cy0 = 16'(wy0); cx1 = 16'(wx1); cy1 = 16'(wy1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs after acceptance must not matter.
    x0 = 16'sd9; y0 = 16'sd9; x1 = -16'sd3; y1 = 16'sd30; x2 = 16'sd1; y2 = 16'sd1;
    cx0 = 16'sd2; cx1 = 16'sd3; mode = ~m;
    @(negedge clk); busy_after_start = int'(busy);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (toggle) oe = ~oe;
      start = (cyc == poke);
    end
    start = 1'b0; oe = 1'b1;
    if (cyc >= 3000) check({tag, "_timeout"}, 1, 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int ex[$], ey[$], cyc;
    rst = 1'b1; start = 1'b0; oe = 1'b1; mode = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    cx0 = '0; cy0 = '0; cx1 = '0; cy1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_drawing", int'(drawing), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Fill, full window: rows 0..4 of widths 5,4,3,2,1.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c <= 4 - r; c++) begin ex.push_back(c); ey.push_back(r); end
    run("fill", 1'b0, 0,0, 4,0, 0,4, 0,0, 15,15, 1'b0, 0);
    check("fill_count", qx.size(), 15);
    check("fill_seq", seq_err(ex, ey, qx, qy), 0);
    check("fill_done", done_cnt, 1);
    check("fill_busy_at_done", busy_at_done, 0);
    check("fill_busy_after_start", busy_after_start, 1);

    // oe toggling every cycle gives the same pixel stream.
    run("fill_oe", 1'b0, 0,0, 4,0, 0,4, 0,0, 15,15, 1'b1, 0);
    check("fill_oe_seq", seq_err(ex, ey, qx, qy), 0);
    check("fill_oe_done", done_cnt, 1);

    // Clipped fill (1,1)-(2,15).
    ex = '{1, 2, 1, 2, 1}; ey = '{1, 1, 2, 2, 3};
    run("clip", 1'b0, 0,0, 4,0, 0,4, 1,1, 2,15, 1'b0, 0);
    check("clip_count", qx.size(), 5);
    check("clip_seq", seq_err(ex, ey, qx, qy), 0);

    // Outline: (0,0)->(3,3)->(0,3)->(0,0) after sort.
    ex = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 0, 0, 0};
    ey = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 2, 1, 0};
    run("outline", 1'b1, 0,0, 3,3, 0,3, 0,0, 15,15, 1'b0, 0);
    check("outline_count", qx.size(), 12);
    check("outline_seq", seq_err(ex, ey, qx, qy), 0);
    check("outline_done", done_cnt, 1);

    run("outline_off", 1'b1, 0,0, 3,3, 0,3, 10,10, 20,20, 1'b0, 0);
    check("outline_off_count", qx.size(), 0);
    check("outline_off_done", done_cnt, 1);

    run("inv_win", 1'b0, 0,0, 4,0, 0,4, 5,0, 4,9, 1'b0, 0);
    check("inv_count", qx.size(), 0);
    check("inv_done", done_cnt, 1);
    check("inv_busy_at_done", busy_at_done, 0);

    // Degenerate shapes.
    ex = '{1, 2, 3, 4, 5}; ey = '{2, 2, 2, 2, 2};
    run("flat", 1'b0, 1,2, 5,2, 3,2, 0,0, 15,15, 1'b0, 0);
    check("flat_seq", seq_err(ex, ey, qx, qy), 0);
    ex = '{7}; ey = '{7};
    run("point", 1'b0, 7,7, 7,7, 7,7, 0,0, 15,15, 1'b0, 0);
    check("point_seq", seq_err(ex, ey, qx, qy), 0);

    // Reset mid-span: outputs clear immediately, no done.
    qx.delete(); qy.delete(); done_cnt = 0;
    @(posedge clk); #1;
    mode = 1'b0; x0 = 0; y0 = 0; x1 = 8; y1 = 0; x2 = 0; y2 = 8;
    cx0 = 0; cy0 = 0; cx1 = 15; cy1 = 15; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (qx.size() < 3 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check("rst_mid_reached_draw", int'(qx.size() >= 3), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_x", int'(x), 0);
    check("rst_mid_y", int'(y), 0);
    check("rst_mid_drawing", int'(drawing), 0);
    check("rst_mid_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_mid_no_done", done_cnt, 0);

    // Full draw after reset, with an ignored start while busy.
    ex.delete(); ey.delete();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c <= 4 - r; c++) begin ex.push_back(c); ey.push_back(r); end
    run("post_rst", 1'b0, 0,0, 4,0, 0,4, 0,0, 15,15, 1'b0, 10);
    check("post_rst_seq", seq_err(ex, ey, qx, qy), 0);
    check("post_rst_done", done_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
